tl_bus_arbiter: RTL and testbench

//  Sequencer/arbiter for the shared TileLink-style A/D bus. Picks one requester (0: icache Get,
//  1: dcache Get/Put), drives the one-hot select for the A-channel mux, and holds that grant

---
 rtl/tl_bus_arbiter_pkg.sv | 32 +++
 rtl/tl_bus_arbiter_rr_pick.sv | 43 ++++
 rtl/tl_bus_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_tl_bus_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tl_bus_arbiter_pkg
//   Shared definitions for the A/D bus arbiter: TileLink opcode constants,
//   the arbiter state encoding and the default beat width.
//   No ports (package).
// -----------------------------------------------------------------------------
package tl_bus_arbiter_pkg;

  // A-channel opcodes
  localparam logic [2:0] TL_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_GET         = 3'd4;

  // D-channel opcodes
  localparam logic [2:0] TL_ACK         = 3'd0;
  localparam logic [2:0] TL_ACK_DATA    = 3'd1;

  // Default data beat width in bytes (32-bit bus)
  localparam int TL_BEAT_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_A    = 2'd1,
    ST_D    = 2'd2
  } arb_state_e;

  // True for the two Put flavours, which carry data on the A channel
  function automatic logic opcode_is_put(input logic [2:0] op);
    return (op == TL_PUT_FULL) || (op == TL_PUT_PARTIAL);
  endfunction

endpackage

// File: rtl/tl_bus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational one-hot selector. With RR=1 the search starts at 'ptr' and
//   wraps; with RR=0 'ptr' is ignored and the lowest set bit wins.
// Ports
//   req  in  N_REQ  request vector
//   ptr  in  IDXW   round-robin start index
//   gnt  out N_REQ  one-hot winner (zero when no request)
//   idx  out IDXW   binary index of the winner (zero when no request)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int RR    = 1,
  parameter int IDXW  = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDXW-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDXW-1:0]  idx
);

  logic            found_s;
  logic [IDXW-1:0] slot_s;

  // Scan the request vector starting at the rotation base, keep the first hit
  always_comb begin
    gnt     = '0;
    idx     = '0;
    found_s = 1'b0;
    slot_s  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      slot_s = (RR != 0) ? IDXW'((int'(ptr) + i) % N_REQ) : IDXW'(i);
      if (!found_s && req[slot_s]) begin
        gnt[slot_s] = 1'b1;
        idx         = slot_s;
        found_s     = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/tl_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tl_bus_arbiter
//   Sequencer/arbiter for the shared TileLink-style A/D bus. Picks one
//   requester, drives the registered one-hot A-mux select and holds it through
//   every A beat and the matching D response, one transaction at a time.
// Ports
//   clock             in   1      clock
//   reset             in   1      asynchronous active-high reset
//   io_req_valid      in   N_REQ  raw per-requester A valid
//   io_a_valid        in   1      muxed A valid
//   io_a_ready        in   1      slave A ready
//   io_a_bits_opcode  in   3      muxed A opcode
//   io_a_bits_size    in   32     muxed A size in bytes
//   io_d_valid        in   1      slave D valid
//   io_d_ready        in   1      master D ready
//   io_d_bits_opcode  in   3      D opcode
//   io_d_bits_source  in   1      D source id
//   io_choseOH        out  N_REQ  registered one-hot grant
//   io_busy           out  1      transaction in progress
//   io_err            out  1      one-cycle pulse on an unexpected D beat
// -----------------------------------------------------------------------------
module tl_bus_arbiter
  import tl_bus_arbiter_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int BEAT_BYTES = TL_BEAT_BYTES,
  parameter int MAX_BYTES  = 64,
  parameter int RR         = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] io_req_valid,
  input  logic             io_a_valid,
  input  logic             io_a_ready,
  input  logic [2:0]       io_a_bits_opcode,
  input  logic [31:0]      io_a_bits_size,
  input  logic             io_d_valid,
  input  logic             io_d_ready,
  input  logic [2:0]       io_d_bits_opcode,
  input  logic             io_d_bits_source,
  output logic [N_REQ-1:0] io_choseOH,
  output logic             io_busy,
  output logic             io_err
);

  localparam int IDXW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int MAX_BEATS = MAX_BYTES / BEAT_BYTES;
  localparam int CNTW      = $clog2(MAX_BEATS) + 1;
  localparam int BB_LOG2   = $clog2(BEAT_BYTES);

  // Beats needed for 'size' bytes: ceil(size/BEAT_BYTES), at least one,
  // clamped to the largest transfer. Shift form avoids overflow near 2^32.
  function automatic logic [CNTW-1:0] calc_beats(input logic [31:0] size);
    logic [31:0] q;
    q = (size >> BB_LOG2) +
        (((size & 32'(BEAT_BYTES - 1)) != 32'd0) ? 32'd1 : 32'd0);
    if (q == 32'd0) begin
      return CNTW'(1);
    end else if (q > 32'(MAX_BEATS)) begin
      return CNTW'(MAX_BEATS);
    end else begin
      return q[CNTW-1:0];
    end
  endfunction

  arb_state_e       state_r;
  arb_state_e       state_nxt_s;

  logic [N_REQ-1:0] choseoh_r;
  logic [IDXW-1:0]  grant_idx_r;
  logic [IDXW-1:0]  rr_ptr_r;
  logic [CNTW-1:0]  a_cnt_r;
  logic [CNTW-1:0]  a_total_r;
  logic [CNTW-1:0]  d_cnt_r;
  logic [31:0]      a_size_r;
  logic             err_r;

  logic [N_REQ-1:0] pick_gnt_s;
  logic [IDXW-1:0]  pick_idx_s;
  logic [CNTW-1:0]  a_total_s;
  logic [CNTW-1:0]  d_total_s;
  logic             a_fire_s;
  logic             d_fire_s;
  logic             src_ok_s;
  logic             grant_s;
  logic             a_beat_s;
  logic             a_last_s;
  logic             d_beat_s;
  logic             d_last_s;
  logic             err_s;

  rr_pick #(
    .N_REQ (N_REQ),
    .RR    (RR),
    .IDXW  (IDXW)
  ) u_pick (
    .req (io_req_valid),
    .ptr (rr_ptr_r),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_nxt_s = ST_A;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_A: begin
        if (a_last_s) begin
          state_nxt_s = ST_D;
        end else begin
          state_nxt_s = ST_A;
        end
      end
      ST_D: begin
        if (d_last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_D;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Per-state beat decode driving the datapath registers
  always_comb begin
    a_fire_s = io_a_valid & io_a_ready;
    d_fire_s = io_d_valid & io_d_ready;
    src_ok_s = (IDXW'(io_d_bits_source) == grant_idx_r);
    // The A beat total is only known on the first beat; later beats reuse it.
    if (a_cnt_r == '0) begin
      a_total_s = opcode_is_put(io_a_bits_opcode) ? calc_beats(io_a_bits_size)
                                                  : CNTW'(1);
    end else begin
      a_total_s = a_total_r;
    end
    d_total_s = (io_d_bits_opcode == TL_ACK_DATA) ? calc_beats(a_size_r)
                                                  : CNTW'(1);
    grant_s  = 1'b0;
    a_beat_s = 1'b0;
    a_last_s = 1'b0;
    d_beat_s = 1'b0;
    d_last_s = 1'b0;
    err_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        grant_s = |io_req_valid;
      end
      ST_A: begin
        a_beat_s = a_fire_s;
        a_last_s = a_fire_s && ((a_cnt_r + CNTW'(1)) == a_total_s);
        // No response may arrive before the request has been fully sent
        err_s    = d_fire_s;
      end
      ST_D: begin
        d_beat_s = d_fire_s && src_ok_s;
        d_last_s = d_beat_s && ((d_cnt_r + CNTW'(1)) == d_total_s);
        err_s    = d_fire_s && !src_ok_s;
      end
      default: begin
        grant_s = 1'b0;
      end
    endcase
  end

  // Grant, round-robin pointer, beat counters, captured size and error pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      choseoh_r   <= '0;
      grant_idx_r <= '0;
      rr_ptr_r    <= '0;
      a_cnt_r     <= '0;
      a_total_r   <= '0;
      d_cnt_r     <= '0;
      a_size_r    <= 32'd0;
      err_r       <= 1'b0;
    end else begin
      err_r <= err_s;
      if (grant_s) begin
        choseoh_r   <= pick_gnt_s;
        grant_idx_r <= pick_idx_s;
      end else if (d_last_s) begin
        choseoh_r <= '0;
        rr_ptr_r  <= (grant_idx_r == IDXW'(N_REQ - 1)) ? '0
                                                       : grant_idx_r + IDXW'(1);
      end
      if (a_beat_s) begin
        if (a_cnt_r == '0) begin
          a_total_r <= a_total_s;
          a_size_r  <= io_a_bits_size;
        end
        a_cnt_r <= a_last_s ? '0 : a_cnt_r + CNTW'(1);
      end
      if (d_beat_s) begin
        d_cnt_r <= d_last_s ? '0 : d_cnt_r + CNTW'(1);
      end
    end
  end

  assign io_choseOH = choseoh_r;
  assign io_busy    = (state_r != ST_IDLE);
  assign io_err     = err_r;

endmodule

// File: tb/tb_tl_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tl_bus_arbiter
//   Two arbiters share all inputs except the D source id: one round-robin,
//   one fixed priority. Expected grants go into per-DUT queues when a request
//   is driven and are popped when the grant appears.
// -----------------------------------------------------------------------------
module tb_tl_bus_arbiter;
  import tl_bus_arbiter_pkg::*;

  logic        clock;
  logic        reset;
  logic [1:0]  req;
  logic        a_valid, a_ready;
  logic [2:0]  a_op;
  logic [31:0] a_size;
  logic        d_valid, d_ready;
  logic [2:0]  d_op;
  logic        d_src_rr, d_src_fx;
  logic [1:0]  choseoh_rr, choseoh_fx;
  logic        busy_rr, busy_fx, err_rr, err_fx;

  int n_vec  = 0;
  int n_miss = 0;

  logic [1:0] q_rr[$];
  logic [1:0] q_fx[$];
  logic [1:0] prev_rr, prev_fx;

  typedef struct {
    logic [1:0]  req;
    logic [2:0]  a_op;
    logic [31:0] a_size;
    logic [2:0]  d_op;
    logic [1:0]  g_rr;
    logic [1:0]  g_fx;
    int          a_beats;
    int          d_beats;
    bit          tog;
  } vec_t;

  vec_t vecs[9];

  tl_bus_arbiter #(.N_REQ(2), .BEAT_BYTES(4), .MAX_BYTES(64), .RR(1)) dut_rr (
    .clock(clock), .reset(reset), .io_req_valid(req),
    .io_a_valid(a_valid), .io_a_ready(a_ready),
    .io_a_bits_opcode(a_op), .io_a_bits_size(a_size),
    .io_d_valid(d_valid), .io_d_ready(d_ready),
    .io_d_bits_opcode(d_op), .io_d_bits_source(d_src_rr),
    .io_choseOH(choseoh_rr), .io_busy(busy_rr), .io_err(err_rr)
  );

  tl_bus_arbiter #(.N_REQ(2), .BEAT_BYTES(4), .MAX_BYTES(64), .RR(0)) dut_fx (
    .clock(clock), .reset(reset), .io_req_valid(req),
    .io_a_valid(a_valid), .io_a_ready(a_ready),
    .io_a_bits_opcode(a_op), .io_a_bits_size(a_size),
    .io_d_valid(d_valid), .io_d_ready(d_ready),
    .io_d_bits_opcode(d_op), .io_d_bits_source(d_src_fx),
    .io_choseOH(choseoh_fx), .io_busy(busy_fx), .io_err(err_fx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Grant scoreboard: a fresh grant (zero -> non-zero) pops the next expectation
  always @(negedge clock) begin
    if (prev_rr == 2'b00 && choseoh_rr != 2'b00) begin
      if (q_rr.size() == 0) check("grant_rr_unexpected", {30'd0, choseoh_rr}, 32'd0);
      else check("grant_rr", {30'd0, choseoh_rr}, {30'd0, q_rr.pop_front()});
    end
    if (prev_fx == 2'b00 && choseoh_fx != 2'b00) begin
      if (q_fx.size() == 0) check("grant_fx_unexpected", {30'd0, choseoh_fx}, 32'd0);
      else check("grant_fx", {30'd0, choseoh_fx}, {30'd0, q_fx.pop_front()});
    end
    prev_rr <= choseoh_rr;
    prev_fx <= choseoh_fx;
  end

  // Request, wait for the grant (bounded), push expectations
  task automatic request(input logic [1:0] r, input logic [1:0] g_rr, input logic [1:0] g_fx);
    int w;
    q_rr.push_back(g_rr);
    q_fx.push_back(g_fx);
    req = r;
    w = 0;
    tick();
    while (choseoh_rr == 2'b00 && w < 5) begin
      tick();
      w++;
    end
    check("grant_latency", w, 0);
  endtask

  task automatic run_txn(input vec_t v);
    int  fired, guard;
    bit  probed;
    request(v.req, v.g_rr, v.g_fx);
    d_src_rr = (v.g_rr == 2'b10);
    d_src_fx = (v.g_fx == 2'b10);
    d_op     = v.d_op;
    a_op     = v.a_op;
    a_size   = v.a_size;
    a_valid  = 1'b1;
    fired = 0; guard = 0; probed = 1'b0;
    while (fired < v.a_beats && guard < 200) begin
      // One A beat short of the end a D beat must still be rejected
      if (v.a_beats > 1 && fired == v.a_beats - 1 && !probed) begin
        probed  = 1'b1;
        a_valid = 1'b0;
        d_valid = 1'b1;
        d_ready = 1'b1;
        tick();
        d_valid = 1'b0;
        check("early_d_err_rr", err_rr, 1);
        check("early_d_err_fx", err_fx, 1);
        a_valid = 1'b1;
      end
      a_ready = v.tog ? ($urandom_range(0, 1) != 0) : 1'b1;
      tick();
      if (a_ready) fired++;
      guard++;
    end
    a_valid = 1'b0;
    a_ready = 1'b0;
    check("a_beats_sent", fired, v.a_beats);
    check("hold_a_rr", {30'd0, choseoh_rr}, {30'd0, v.g_rr});
    check("hold_a_fx", {30'd0, choseoh_fx}, {30'd0, v.g_fx});
    d_valid = 1'b1;
    d_ready = 1'b1;
    for (int k = 0; k < v.d_beats; k++) begin
      tick();
      check("d_err_rr", err_rr, 0);
      check("d_err_fx", err_fx, 0);
      if (k < v.d_beats - 1) begin
        check("d_busy_rr", busy_rr, 1);
        check("d_busy_fx", busy_fx, 1);
        check("d_hold_rr", {30'd0, choseoh_rr}, {30'd0, v.g_rr});
      end else begin
        check("done_busy_rr", busy_rr, 0);
        check("done_busy_fx", busy_fx, 0);
        check("done_gnt_rr", {30'd0, choseoh_rr}, 32'd0);
        check("done_gnt_fx", {30'd0, choseoh_fx}, 32'd0);
      end
    end
    d_valid = 1'b0;
  endtask

  vec_t v_after_rst;

  initial begin
    //        req    a_op            size      d_op        g_rr   g_fx   aB  dB  tog
    vecs[0] = '{2'b01, TL_GET,         32'h20,   TL_ACK_DATA, 2'b01, 2'b01, 1,  8,  1'b0};
    vecs[1] = '{2'b10, TL_PUT_FULL,    32'h10,   TL_ACK,      2'b10, 2'b10, 4,  1,  1'b1};
    vecs[2] = '{2'b11, TL_GET,         32'h8,    TL_ACK_DATA, 2'b01, 2'b01, 1,  2,  1'b0};
    vecs[3] = '{2'b11, TL_GET,         32'h8,    TL_ACK_DATA, 2'b10, 2'b01, 1,  2,  1'b0};
    vecs[4] = '{2'b11, TL_GET,         32'h8,    TL_ACK_DATA, 2'b01, 2'b01, 1,  2,  1'b0};
    vecs[5] = '{2'b11, TL_PUT_PARTIAL, 32'h0,    TL_ACK,      2'b10, 2'b01, 1,  1,  1'b0};
    vecs[6] = '{2'b01, TL_PUT_FULL,    32'd100,  TL_ACK,      2'b01, 2'b01, 16, 1,  1'b0};
    vecs[7] = '{2'b10, TL_GET,         32'h1000, TL_ACK_DATA, 2'b10, 2'b10, 1,  16, 1'b0};
    vecs[8] = '{2'b01, TL_PUT_FULL,    32'd6,    TL_ACK,      2'b01, 2'b01, 2,  1,  1'b1};
    v_after_rst = '{2'b11, TL_GET, 32'h4, TL_ACK_DATA, 2'b01, 2'b01, 1, 1, 1'b0};

    reset = 1'b1; req = 2'b00;
    a_valid = 1'b0; a_ready = 1'b0; a_op = TL_GET; a_size = 32'd0;
    d_valid = 1'b0; d_ready = 1'b0; d_op = TL_ACK; d_src_rr = 1'b0; d_src_fx = 1'b0;
    tick(); tick();
    check("rst_gnt_rr", {30'd0, choseoh_rr}, 32'd0);
    check("rst_busy_rr", busy_rr, 0);
    check("rst_err_rr", err_rr, 0);
    check("rst_gnt_fx", {30'd0, choseoh_fx}, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_gnt_rr", {30'd0, choseoh_rr}, 32'd0);
    check("idle_busy_rr", busy_rr, 0);

    foreach (vecs[i]) run_txn(vecs[i]);
    req = 2'b00;

    // Reset in the middle of a D burst, then serve from pointer 0
    request(2'b01, 2'b01, 2'b01);
    req = 2'b00;
    a_op = TL_GET; a_size = 32'h20; a_valid = 1'b1; a_ready = 1'b1;
    tick();
    a_valid = 1'b0; a_ready = 1'b0;
    d_op = TL_ACK_DATA; d_src_rr = 1'b0; d_src_fx = 1'b0; d_valid = 1'b1; d_ready = 1'b1;
    tick(); tick(); tick();
    d_valid = 1'b0;
    check("mid_d_busy_rr", busy_rr, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_gnt_rr", {30'd0, choseoh_rr}, 32'd0);
    check("async_rst_busy_rr", busy_rr, 0);
    check("async_rst_gnt_fx", {30'd0, choseoh_fx}, 32'd0);
    check("async_rst_busy_fx", busy_fx, 0);
    tick();
    reset = 1'b0;
    run_txn(v_after_rst);
    req = 2'b00;

    // Stray D beats: one during A, one with the wrong source during D
    request(2'b10, 2'b10, 2'b10);
    req = 2'b00;
    d_op = TL_ACK_DATA; d_src_rr = 1'b1; d_src_fx = 1'b1; d_valid = 1'b1; d_ready = 1'b1;
    tick();
    d_valid = 1'b0;
    check("a_state_d_err", err_rr, 1);
    a_op = TL_GET; a_size = 32'h8; a_valid = 1'b1; a_ready = 1'b1;
    tick();
    a_valid = 1'b0; a_ready = 1'b0;
    check("err_cleared", err_rr, 0);
    d_src_rr = 1'b0; d_src_fx = 1'b0; d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    check("bad_src_err_rr", err_rr, 1);
    check("bad_src_err_fx", err_fx, 1);
    check("bad_src_busy", busy_rr, 1);
    tick();
    check("err_one_cycle", err_rr, 0);
    d_src_rr = 1'b1; d_src_fx = 1'b1; d_valid = 1'b1;
    tick();
    check("bad_src_not_counted", busy_rr, 1);
    check("bad_src_hold", {30'd0, choseoh_rr}, 32'h2);
    tick();
    d_valid = 1'b0;
    check("bad_src_done_busy", busy_rr, 0);
    check("bad_src_done_gnt", {30'd0, choseoh_rr}, 32'd0);
    check("bad_src_done_err", err_rr, 0);

    tick(); tick();
    check("sb_rr_drained", q_rr.size(), 0);
    check("sb_fx_drained", q_fx.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
